clock_reg_ctrl: RTL and testbench

- Register-interface front end for the crypto clock selector. Lives on the USB clock domain.
- Holds the 5-bit clock-settings register and drives it to the clock select/output stage.
- Sequences every effective clock change: first asserts a hold on the crypto logic, then switches the selection, then waits a settle time, then releases the hold.
- Also synchronises the J16/K16 DIP selects, which take effect when the register is in DIP mode (bit 0 = 0).

---
 rtl/clock_reg_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_clock_reg_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_reg_ctrl.sv
// Register front end for the crypto clock selector: holds the clock-settings
// register and sequences hold -> switch -> settle -> release on every change.
module clock_reg_ctrl #(
  parameter int                     pADDR_WIDTH    = 8,
  parameter logic [pADDR_WIDTH-1:0] pCLKSET_ADDR   = 8'h05,
  parameter logic [pADDR_WIDTH-1:0] pSTATUS_ADDR   = 8'h06,
  parameter int                     pHOLD_CYCLES   = 16,
  parameter int                     pSETTLE_CYCLES = 256
) (
  input  logic                   usb_clk,
  input  logic                   reset,
  input  logic [pADDR_WIDTH-1:0] I_reg_addr,
  input  logic                   I_reg_write,
  input  logic                   I_reg_read,
  input  logic [7:0]             I_reg_datai,
  output logic [7:0]             O_reg_datao,
  input  logic                   I_j16_sel,
  input  logic                   I_k16_sel,
  output logic [4:0]             O_clock_reg,
  output logic                   O_j16_sel_sync,
  output logic                   O_k16_sel_sync,
  output logic                   O_crypto_hold,
  output logic                   O_busy
);

  localparam int HW = $clog2(pHOLD_CYCLES);
  localparam int SW = $clog2(pSETTLE_CYCLES);
  localparam int CW = ((HW > SW) ? HW : SW) + 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(pHOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(pSETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_HOLD, ST_SETTLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    shadow_q, shadow_d;
  logic [4:0]    clock_reg_q, clock_reg_d;
  logic          j16_q, j16_d, k16_q, k16_d;
  logic          hold_q, hold_d, busy_q, busy_d;
  logic [7:0]    datao_q, datao_d;

  logic j16_meta_q, j16_meta_d, j16_sync_q, j16_sync_d, j16_hist_q, j16_hist_d;
  logic k16_meta_q, k16_meta_d, k16_sync_q, k16_sync_d, k16_hist_q, k16_hist_d;

  logic dip_mode, j16_stable, k16_stable, dip_diff, change_req, capture;

  logic unused_datai;
  assign unused_datai = ^I_reg_datai[7:5];

  always_comb begin
    j16_meta_d = I_j16_sel;
    j16_sync_d = j16_meta_q;
    j16_hist_d = j16_sync_q;
    k16_meta_d = I_k16_sel;
    k16_sync_d = k16_meta_q;
    k16_hist_d = k16_sync_q;
  end

  // A DIP value only counts once it has held for two samples, so a
  // one-sample glitch never starts a sequence.
  always_comb begin
    dip_mode   = ~clock_reg_q[0];
    j16_stable = (j16_sync_q == j16_hist_q);
    k16_stable = (k16_sync_q == k16_hist_q);
    dip_diff   = (j16_stable && (j16_sync_q != j16_q)) ||
                 (k16_stable && (k16_sync_q != k16_q));
    change_req = (shadow_q != clock_reg_q) || (dip_mode && dip_diff);
  end

  always_comb begin
    shadow_d = shadow_q;
    if (I_reg_write && (I_reg_addr == pCLKSET_ADDR))
      shadow_d = I_reg_datai[4:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (change_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = change_req ? ST_HOLD : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // The new selection is registered on entry to the final HOLD cycle, so it
  // is already visible while hold is still asserted for that cycle.
  always_comb begin
    capture     = (state_d == ST_HOLD) && (cnt_d == HOLD_LAST);
    clock_reg_d = clock_reg_q;
    j16_d       = j16_q;
    k16_d       = k16_q;
    if (capture) begin
      clock_reg_d = shadow_q;
      j16_d       = j16_sync_q;
      k16_d       = k16_sync_q;
    end else if ((state_q == ST_IDLE) && !dip_mode) begin
      if (j16_stable) j16_d = j16_sync_q;
      if (k16_stable) k16_d = k16_sync_q;
    end
    hold_d = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    datao_d = datao_q;
    if (I_reg_read) begin
      if (I_reg_addr == pCLKSET_ADDR)
        datao_d = {3'b000, shadow_q};
      else if (I_reg_addr == pSTATUS_ADDR)
        datao_d = {3'b000, busy_q, hold_q, j16_q, k16_q, clock_reg_q[0]};
      else
        datao_d = 8'h00;
    end
  end

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      shadow_q    <= '0;
      clock_reg_q <= '0;
      j16_q       <= 1'b0;
      k16_q       <= 1'b0;
      hold_q      <= 1'b1;
      busy_q      <= 1'b1;
      datao_q     <= '0;
      j16_meta_q  <= 1'b0;
      j16_sync_q  <= 1'b0;
      j16_hist_q  <= 1'b0;
      k16_meta_q  <= 1'b0;
      k16_sync_q  <= 1'b0;
      k16_hist_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      clock_reg_q <= clock_reg_d;
      j16_q       <= j16_d;
      k16_q       <= k16_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      datao_q     <= datao_d;
      j16_meta_q  <= j16_meta_d;
      j16_sync_q  <= j16_sync_d;
      j16_hist_q  <= j16_hist_d;
      k16_meta_q  <= k16_meta_d;
      k16_sync_q  <= k16_sync_d;
      k16_hist_q  <= k16_hist_d;
    end
  end

  assign O_clock_reg    = clock_reg_q;
  assign O_j16_sel_sync = j16_q;
  assign O_k16_sel_sync = k16_q;
  assign O_crypto_hold  = hold_q;
  assign O_busy         = busy_q;
  assign O_reg_datao    = datao_q;

endmodule

// File: tb/tb_clock_reg_ctrl.sv
// Directed bench for clock_reg_ctrl: reset settle, change latency, chained
// changes, no-op writes, DIP handling and reset in the middle of a sequence.
module tb_clock_reg_ctrl;

  logic       usb_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] I_reg_addr  = 8'h00;
  logic       I_reg_write = 1'b0;
  logic       I_reg_read  = 1'b0;
  logic [7:0] I_reg_datai = 8'h00;
  logic [7:0] O_reg_datao;
  logic       I_j16_sel = 1'b0;
  logic       I_k16_sel = 1'b0;
  logic [4:0] O_clock_reg;
  logic       O_j16_sel_sync, O_k16_sel_sync, O_crypto_hold, O_busy;

  int checks = 0;
  int errors = 0;

  clock_reg_ctrl dut (
    .usb_clk(usb_clk), .reset(reset),
    .I_reg_addr(I_reg_addr), .I_reg_write(I_reg_write), .I_reg_read(I_reg_read),
    .I_reg_datai(I_reg_datai), .O_reg_datao(O_reg_datao),
    .I_j16_sel(I_j16_sel), .I_k16_sel(I_k16_sel),
    .O_clock_reg(O_clock_reg), .O_j16_sel_sync(O_j16_sel_sync),
    .O_k16_sel_sync(O_k16_sel_sync), .O_crypto_hold(O_crypto_hold), .O_busy(O_busy)
  );

  always #5 usb_clk = ~usb_clk;

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  // Returns sitting 1 time unit after the edge that sampled the strobe (edge 1).
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    I_reg_addr  = a;
    I_reg_datai = d;
    I_reg_write = 1'b1;
    tick();
    I_reg_write = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d);
    I_reg_addr = a;
    I_reg_read = 1'b1;
    tick();
    d = O_reg_datao;
    I_reg_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    repeat (3) tick();
    checks++;
    if (O_crypto_hold !== 1'b1 || O_busy !== 1'b1) begin
      errors++; $display("FAIL reset_hold_busy got %b%b want 11", O_crypto_hold, O_busy);
    end
    checks++;
    if (O_clock_reg !== 5'd0 || O_reg_datao !== 8'h00 || O_j16_sel_sync !== 1'b0 || O_k16_sel_sync !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got clk=%h dat=%h j=%b k=%b want 0", O_clock_reg, O_reg_datao, O_j16_sel_sync, O_k16_sel_sync);
    end
    reset = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (n == 255) begin
        checks++;
        if (O_crypto_hold !== 1'b1) begin
          errors++; $display("FAIL init_hold_255 got %b want 1", O_crypto_hold);
        end
      end
    end
    checks++;
    if (O_crypto_hold !== 1'b0 || O_busy !== 1'b0) begin
      errors++; $display("FAIL init_release_256 got %b%b want 00", O_crypto_hold, O_busy);
    end
    do_read(8'h06, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL status_after_init got %h want 00", rd);
    end
  endtask

  task automatic test_write_latency();
    logic [7:0] rd;
    do_write(8'h05, 8'h05);
    checks++;
    if (O_crypto_hold !== 1'b0) begin
      errors++; $display("FAIL lat_hold_c1 got %b want 0", O_crypto_hold);
    end
    for (int n = 2; n <= 274; n++) begin
      tick();
      if (n == 2) begin
        checks++;
        if (O_crypto_hold !== 1'b1 || O_busy !== 1'b1) begin
          errors++; $display("FAIL lat_hold_c2 got %b%b want 11", O_crypto_hold, O_busy);
        end
      end
      if (n == 16) begin
        checks++;
        if (O_clock_reg !== 5'd0) begin
          errors++; $display("FAIL lat_clk_c16 got %h want 00", O_clock_reg);
        end
      end
      if (n == 17) begin
        checks++;
        if (O_clock_reg !== 5'b00101) begin
          errors++; $display("FAIL lat_clk_c17 got %h want 05", O_clock_reg);
        end
      end
      if (n == 273) begin
        checks++;
        if (O_crypto_hold !== 1'b1) begin
          errors++; $display("FAIL lat_hold_c273 got %b want 1", O_crypto_hold);
        end
      end
    end
    checks++;
    if (O_crypto_hold !== 1'b0 || O_busy !== 1'b0) begin
      errors++; $display("FAIL lat_release_c274 got %b%b want 00", O_crypto_hold, O_busy);
    end
    do_read(8'h05, rd);
    checks++;
    if (rd !== 8'h05) begin
      errors++; $display("FAIL readback_clkset got %h want 05", rd);
    end
    do_read(8'h06, rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++; $display("FAIL status_bit0 got %h want 01", rd);
    end
    do_read(8'h33, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL read_unmapped got %h want 00", rd);
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    do_write(8'h05, 8'h02);
    for (int n = 2; n <= 546; n++) begin
      tick();
      if (n == 49) begin
        I_reg_addr = 8'h05; I_reg_datai = 8'h01; I_reg_write = 1'b1;
      end
      if (n == 50) I_reg_write = 1'b0;
      if (n <= 545 && O_crypto_hold !== 1'b1) gaps++;
      if (n == 100) begin
        checks++;
        if (O_clock_reg !== 5'd2) begin
          errors++; $display("FAIL b2b_first got %h want 02", O_clock_reg);
        end
      end
      if (n == 289) begin
        checks++;
        if (O_clock_reg !== 5'd1) begin
          errors++; $display("FAIL b2b_second_capture got %h want 01", O_clock_reg);
        end
      end
    end
    checks++;
    if (gaps !== 0) begin
      errors++; $display("FAIL b2b_hold_gap got %0d gap cycles want 0", gaps);
    end
    checks++;
    if (O_crypto_hold !== 1'b0 || O_clock_reg !== 5'd1) begin
      errors++; $display("FAIL b2b_final got hold=%b clk=%h want hold=0 clk=01", O_crypto_hold, O_clock_reg);
    end
  endtask

  task automatic test_same_value();
    int seen = 0;
    logic [7:0] rd;
    do_write(8'h05, 8'h01);
    repeat (40) begin tick(); if (O_crypto_hold || O_busy) seen++; end
    do_write(8'h05, 8'hE1);
    repeat (40) begin tick(); if (O_crypto_hold || O_busy) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL same_value_no_seq got %0d busy cycles want 0", seen);
    end
    do_read(8'h05, rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++; $display("FAIL high_bits_ignored got %h want 01", rd);
    end
  endtask

  task automatic test_dip();
    int seen = 0;
    int guard;
    logic [7:0] rd;
    // Register bit 0 = 1: DIP copies follow silently.
    I_j16_sel = 1'b1;
    repeat (10) begin tick(); if (O_crypto_hold) seen++; end
    checks++;
    if (seen !== 0 || O_j16_sel_sync !== 1'b1) begin
      errors++; $display("FAIL dip_silent got hold_cycles=%0d j16=%b want 0 1", seen, O_j16_sel_sync);
    end
    I_j16_sel = 1'b0;
    repeat (10) begin tick(); if (O_crypto_hold) seen++; end
    checks++;
    if (seen !== 0 || O_j16_sel_sync !== 1'b0) begin
      errors++; $display("FAIL dip_silent_back got hold_cycles=%0d j16=%b want 0 0", seen, O_j16_sel_sync);
    end
    // DIP mode: a J16 change runs a full sequence.
    do_write(8'h05, 8'h00);
    repeat (300) tick();
    checks++;
    if (O_clock_reg !== 5'd0 || O_crypto_hold !== 1'b0) begin
      errors++; $display("FAIL dip_mode_enter got clk=%h hold=%b want 00 0", O_clock_reg, O_crypto_hold);
    end
    I_j16_sel = 1'b1;
    guard = 0;
    while (!O_crypto_hold && guard < 20) begin tick(); guard++; end
    checks++;
    if (O_crypto_hold !== 1'b1) begin
      errors++; $display("FAIL dip_seq_start got %b want 1 within 20 cycles", O_crypto_hold);
    end
    guard = 0;
    while (O_crypto_hold && guard < 400) begin tick(); guard++; end
    checks++;
    if (O_crypto_hold !== 1'b0 || O_j16_sel_sync !== 1'b1 || O_clock_reg !== 5'd0) begin
      errors++; $display("FAIL dip_seq_end got hold=%b j16=%b clk=%h want 0 1 00", O_crypto_hold, O_j16_sel_sync, O_clock_reg);
    end
    do_read(8'h06, rd);
    checks++;
    if (rd !== 8'h04) begin
      errors++; $display("FAIL dip_status got %h want 04", rd);
    end
    // One-cycle K16 glitch must not start a sequence.
    seen = 0;
    I_k16_sel = 1'b1;
    tick();
    I_k16_sel = 1'b0;
    repeat (20) begin tick(); if (O_crypto_hold) seen++; end
    checks++;
    if (seen !== 0 || O_k16_sel_sync !== 1'b0) begin
      errors++; $display("FAIL dip_glitch got hold_cycles=%0d k16=%b want 0 0", seen, O_k16_sel_sync);
    end
    I_j16_sel = 1'b0;
    repeat (10) tick();
    guard = 0;
    while (O_crypto_hold && guard < 600) begin tick(); guard++; end
    checks++;
    if (O_crypto_hold !== 1'b0) begin
      errors++; $display("FAIL dip_restore_timeout got hold=%b want 0", O_crypto_hold);
    end
  endtask

  task automatic test_reset_mid_hold();
    int seen = 0;
    logic [7:0] rd;
    do_write(8'h05, 8'h03);
    for (int n = 2; n <= 17; n++) tick();
    checks++;
    if (O_clock_reg !== 5'd3 || O_crypto_hold !== 1'b1) begin
      errors++; $display("FAIL mid_capture got clk=%h hold=%b want 03 1", O_clock_reg, O_crypto_hold);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (O_clock_reg !== 5'd0 || O_crypto_hold !== 1'b1 || O_busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset_async got clk=%h hold=%b busy=%b want 00 1 1", O_clock_reg, O_crypto_hold, O_busy);
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (n == 255) begin
        checks++;
        if (O_crypto_hold !== 1'b1) begin
          errors++; $display("FAIL mid_init_255 got %b want 1", O_crypto_hold);
        end
      end
    end
    checks++;
    if (O_crypto_hold !== 1'b0 || O_clock_reg !== 5'd0) begin
      errors++; $display("FAIL mid_init_256 got hold=%b clk=%h want 0 00", O_crypto_hold, O_clock_reg);
    end
    do_read(8'h05, rd);
    repeat (20) begin tick(); if (O_crypto_hold) seen++; end
    checks++;
    if (rd !== 8'h00 || seen !== 0) begin
      errors++; $display("FAIL mid_shadow_discard got rd=%h hold_cycles=%0d want 00 0", rd, seen);
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_same_value();
    test_dip();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
